sram_burst_ctrl: RTL
====================

// Module: sram_burst_ctrl
// PURPOSE
//  Initiator side of the single-port sram bus: turns burst commands into sram pin activity
//  (cs, we, rd, addr, wr_data), one beat per clock.
//  Sits between a requesting engine and an sram instance. Streams write data in and read data out.
//  Supports ascending or descending bursts with wrap-around.
// PARAMETERS
//  ADDRESS_BITS  5   sram address width
//  DATA_WIDTH    8   sram data width
//  NUM_REG       32  sram depth; addresses 0..NUM_REG-1, wrap point
//  RD_LAT        1   cycles from read-issue cycle to rd_data valid (>=1)
// PORTS
//  clk           in   1             rising-edge clock
//  rst_n         in   1             asynchronous active-low reset
//  cmd_valid     in   1             command offered
//  cmd_ready     out  1             command accepted when cmd_valid&cmd_ready
//  cmd_we        in   1             1=write burst, 0=read burst
//  cmd_dir       in   1             0=addr+1 per beat, 1=addr-1 per beat
//  cmd_addr      in   ADDRESS_BITS  first address (<NUM_REG)
//  cmd_len       in   ADDRESS_BITS  beats-1 (1..NUM_REG beats)
//  wd_valid      in   1             write data offered
//  wd_ready      out  1             write data consumed when wd_valid&wd_ready
//  wd_data       in   DATA_WIDTH    write data
//  rdo_valid     out  1             read data valid (sink always ready, no backpressure)
//  rdo_data      out  DATA_WIDTH    read data
//  busy          out  1             state != IDLE or reads in flight
//  done          out  1             one-cycle completion pulse
//  sram_cs       out  1             chip select, active-high
//  sram_we       out  1             write enable, active-high
//  sram_rd       out  1             read enable, active-low
//  sram_addr     out  ADDRESS_BITS  sram address
//  sram_wr_data  out  DATA_WIDTH    sram write data
//  sram_rd_data  in   DATA_WIDTH    sram read data
// BEHAVIOUR
//  Reset: IDLE, cmd_ready=1, wd_ready=0, rdo_valid=0, busy=0, done=0.
//   sram_cs=0, sram_we=0, sram_rd=1, sram_addr=0, sram_wr_data=0. In-flight read tracking cleared.
//  FSM IDLE -> WRITE (accept, cmd_we=1) | READ (accept, cmd_we=0).
//   READ -> DRAIN (last read issued). WRITE/DRAIN -> IDLE.
//  cmd_ready=1 only in IDLE with no reads in flight.
//   Command fields are latched on accept; later cmd_* changes are ignored.
//  sram_* are combinational from state/counters. A beat is the cycle the sram samples at its end.
//  WRITE: wd_ready=1. Beat when wd_valid=1: cs=1, we=1, rd=1, addr=cur, wr_data=wd_data.
//   Cycle with wd_valid=0: cs=0, we=0, no addr/count change (stall).
//   After beat len+1 -> IDLE.
//  READ: every cycle is a beat (cs=1, we=0, rd=0, addr=cur). After len+1 beats -> DRAIN.
//  DRAIN: cs=0, rd=1; waits until tracker empty, then -> IDLE.
//  Read return: beat in cycle t -> rdo_valid=1 in cycle t+RD_LAT, rdo_data=sram_rd_data
//   (combinational pass-through). Order = issue order.
//  Address step per beat: dir=0: NUM_REG-1 -> 0. dir=1: 0 -> NUM_REG-1. Never leaves 0..NUM_REG-1.
//  Beat counter ADDRESS_BITS wide, counts len down to 0. cmd_len=0 gives one beat.
//  done: registered pulse in first IDLE cycle after the last write beat or the last rdo_valid.
//   cmd_ready is also 1 that cycle, so back-to-back commands lose no cycle.
//  rst_n low mid-burst: pins idle immediately (async). Outstanding reads discarded; no done pulse.
//  Illegal cmd_addr>=NUM_REG: behaviour undefined; bench must not drive it.
// STRUCTURE
//  Include sram_ctrl_defs.vh: FSM state codes (IDLE, WRITE, READ, DRAIN).
//   Also pin idle levels (CS_IDLE=0, WE_IDLE=0, RD_IDLE=1).
//  Sub-module sram_rd_tracker: RD_LAT-deep valid shift register, outputs rdo_valid and empty.
// TESTING (bench instantiates sram_burst_ctrl + sram, STEP=20ns)
//  1 Write addr=0 dir=0 len=31, wd_data 0,3,6..93 back-to-back
//    -> 32 beats in 32 cycles, done 1 cycle after last.
//  2 Read addr=31 dir=1 len=31
//    -> rdo_data 93,90..0, rdo_valid RD_LAT after each beat, done after last.
//  3 Write addr=30 dir=0 len=3 -> sram_addr 30,31,0,1.
//    Read addr=1 dir=1 len=3 -> addrs 1,0,31,30.
//  4 Write len=3 with wd_valid low 2 cycles mid-burst -> sram_cs=0 those cycles, addr holds, 4 beats total.
//  5 cmd_valid held high during burst -> no second accept until done cycle; then accepted that cycle.
//  6 rst_n=0 during read beat 5 of 16 -> pins idle same cycle, rdo_valid=0, busy=0, no done.

Source files
------------

// File: rtl/sram_burst_ctrl_pkg.sv
// Types and pin idle levels shared by the sram burst controller and its read tracker.
// Encodings come from the shared defines so other blocks decoding the pins agree on them.
`include "sram_ctrl_defs.sv"

package sram_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = `SRAM_ST_IDLE,
    WRITE = `SRAM_ST_WRITE,
    READ  = `SRAM_ST_READ,
    DRAIN = `SRAM_ST_DRAIN
  } state_t;

  localparam logic CS_IDLE = `SRAM_CS_IDLE;
  localparam logic WE_IDLE = `SRAM_WE_IDLE;
  localparam logic RD_IDLE = `SRAM_RD_IDLE;

endpackage

// File: rtl/sram_ctrl_defs.sv
// Shared encodings for the sram burst controller: FSM state codes and sram pin idle levels.
// Guarded so it can be both compiled on its own and pulled into the package.
`ifndef SRAM_CTRL_DEFS_SV
`define SRAM_CTRL_DEFS_SV

`define SRAM_ST_IDLE  2'd0
`define SRAM_ST_WRITE 2'd1
`define SRAM_ST_READ  2'd2
`define SRAM_ST_DRAIN 2'd3

`define SRAM_CS_IDLE  1'b0
`define SRAM_WE_IDLE  1'b0
`define SRAM_RD_IDLE  1'b1

`endif

// File: rtl/sram_rd_tracker.sv
// Tracks issued sram reads: RD_LAT-deep valid shift, rdo_valid exactly RD_LAT cycles after issue.
// No backpressure; empty_nxt says the pipe drains this cycle if nothing new is issued.
module sram_rd_tracker #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  output logic rdo_valid,
  output logic empty,
  output logic empty_nxt
);

  logic [RD_LAT-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign rdo_valid = pipe[RD_LAT-1];
  assign empty     = (pipe == '0);
  // Only the stage leaving this cycle may be set for the pipe to be empty next cycle.
  assign empty_nxt = ((pipe << 1) == '0);

endmodule

// File: rtl/sram_burst_ctrl.sv
// Turns burst commands into single-port sram pin activity, one beat per clock, with address wrap.
// Writes stall on wd_valid=0; reads return RD_LAT cycles after issue with no backpressure.
module sram_burst_ctrl
  import sram_burst_ctrl_pkg::*;
#(
  parameter int ADDRESS_BITS = 5,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REG      = 32,
  parameter int RD_LAT       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic                    cmd_dir,
  input  logic [ADDRESS_BITS-1:0] cmd_addr,
  input  logic [ADDRESS_BITS-1:0] cmd_len,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  output logic                    rdo_valid,
  output logic [DATA_WIDTH-1:0]   rdo_data,
  output logic                    busy,
  output logic                    done,
  output logic                    sram_cs,
  output logic                    sram_we,
  output logic                    sram_rd,
  output logic [ADDRESS_BITS-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wr_data,
  input  logic [DATA_WIDTH-1:0]   sram_rd_data
);

  localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = ADDRESS_BITS'(NUM_REG - 1);

  state_t                  state, state_nxt;
  logic [ADDRESS_BITS-1:0] cur_addr;
  logic [ADDRESS_BITS-1:0] beat_cnt;
  logic                    dir_q;
  logic                    done_q;
  logic                    beat;
  logic                    rd_issue;
  logic                    accept;
  logic                    trk_empty;
  logic                    trk_empty_nxt;

  function automatic logic [ADDRESS_BITS-1:0] step_addr(input logic [ADDRESS_BITS-1:0] a,
                                                        input logic                    d);
    if (d) step_addr = (a == '0) ? LAST_ADDR : a - 1'b1;
    else   step_addr = (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  assign accept = cmd_valid & cmd_ready;

  always_comb begin
    state_nxt    = state;
    cmd_ready    = 1'b0;
    wd_ready     = 1'b0;
    beat         = 1'b0;
    rd_issue     = 1'b0;
    sram_cs      = CS_IDLE;
    sram_we      = WE_IDLE;
    sram_rd      = RD_IDLE;
    sram_addr    = '0;
    sram_wr_data = '0;
    case (state)
      IDLE: begin
        cmd_ready = trk_empty;
        if (cmd_valid && trk_empty) state_nxt = cmd_we ? WRITE : READ;
      end
      WRITE: begin
        wd_ready  = 1'b1;
        sram_addr = cur_addr;
        if (wd_valid) begin
          beat         = 1'b1;
          sram_cs      = 1'b1;
          sram_we      = 1'b1;
          sram_wr_data = wd_data;
          if (beat_cnt == '0) state_nxt = IDLE;
        end
      end
      READ: begin
        beat      = 1'b1;
        rd_issue  = 1'b1;
        sram_cs   = 1'b1;
        sram_rd   = 1'b0;
        sram_addr = cur_addr;
        if (beat_cnt == '0) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (trk_empty_nxt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // done lands in the first IDLE cycle, the same cycle cmd_ready can take the next command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      beat_cnt <= '0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= ((state == WRITE) && beat && (beat_cnt == '0)) ||
                ((state == DRAIN) && trk_empty_nxt);
      if (accept) begin
        cur_addr <= cmd_addr;
        beat_cnt <= cmd_len;
        dir_q    <= cmd_dir;
      end else if (beat) begin
        cur_addr <= step_addr(cur_addr, dir_q);
        beat_cnt <= beat_cnt - 1'b1;
      end
    end
  end

  sram_rd_tracker #(
    .RD_LAT (RD_LAT)
  ) u_rd_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (rd_issue),
    .rdo_valid (rdo_valid),
    .empty     (trk_empty),
    .empty_nxt (trk_empty_nxt)
  );

  assign rdo_data = sram_rd_data;
  assign done     = done_q;
  assign busy     = (state != IDLE) | ~trk_empty;

endmodule
